// File: rtl/reset_sequencer_if.sv
// Control/status bundle between the reset sequencer and the blocks it sequences.
// master: the sequencer; slave: clock manager, software and the gated stages.
interface reset_sequencer_if;
    logic       locked;
    logic       soft_reset_req;
    logic [2:0] stage_done;
    logic [2:0] rst_stage;
    logic       seq_ready;
    logic       fault;
    logic [1:0] fault_stage;
    logic [7:0] lock_loss_cnt;

    modport master (
        input  locked, soft_reset_req, stage_done,
        output rst_stage, seq_ready, fault, fault_stage, lock_loss_cnt
    );

    modport slave (
        output locked, soft_reset_req, stage_done,
        input  rst_stage, seq_ready, fault, fault_stage, lock_loss_cnt
    );
endinterface

// File: rtl/reset_sequencer.sv
// Staged reset release: hold, wait for lock, then free stages 0..2 one at a time,
// each waiting for its done flag, with lock-loss restart and timeout fault.
module reset_sequencer #(
    parameter int unsigned HOLD_CYCLES  = 16,
    parameter int unsigned STAGE_GAP    = 100,
    parameter int unsigned DONE_TIMEOUT = 1000000
) (
    input  logic              clk,
    input  logic              reset,
    reset_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        ST_ASSERT,
        ST_WAIT_LOCK,
        ST_WAIT_DONE,
        ST_GAP,
        ST_RUN,
        ST_FAULT
    } state_t;

    localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] GAP_LAST  = 24'(STAGE_GAP - 1);
    localparam logic [23:0] TO_LAST   = 24'(DONE_TIMEOUT - 1);
    localparam logic [23:0] CNT_MAX   = 24'hFF_FFFF;

    state_t      state;
    state_t      state_nxt;
    logic [23:0] cnt;
    logic [23:0] cnt_nxt;
    logic [1:0]  n;
    logic [1:0]  n_nxt;
    logic        sync1;
    logic        locked_s;
    logic        lock_lost;
    logic [2:0]  rst_nxt;
    logic [1:0]  fstage_nxt;
    logic [7:0]  llc_nxt;

    // locked comes from another clock domain
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync1    <= bus.locked;
            locked_s <= sync1;
        end
    end

    assign lock_lost = !locked_s &&
                       (state == ST_WAIT_DONE ||
                        state == ST_GAP ||
                        state == ST_RUN);

    always_comb begin
        state_nxt  = state;
        n_nxt      = n;
        fstage_nxt = bus.fault_stage;
        llc_nxt    = bus.lock_loss_cnt;
        cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + 24'd1;
        rst_nxt    = 3'b111;

        if (lock_lost) begin
            state_nxt = ST_ASSERT;
            if (bus.lock_loss_cnt != 8'hFF) begin
                llc_nxt = bus.lock_loss_cnt + 8'd1;
            end
        end else if (bus.soft_reset_req && state != ST_ASSERT) begin
            state_nxt = ST_ASSERT;
        end else begin
            unique case (state)
                ST_ASSERT: begin
                    if (cnt == HOLD_LAST) state_nxt = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_WAIT_DONE;
                        n_nxt     = 2'd0;
                    end
                end
                ST_WAIT_DONE: begin
                    if (bus.stage_done[n]) begin
                        state_nxt = (n == 2'd2) ? ST_RUN : ST_GAP;
                    end else if (cnt == TO_LAST) begin
                        state_nxt  = ST_FAULT;
                        fstage_nxt = n;
                    end
                end
                ST_GAP: begin
                    if (cnt == GAP_LAST) begin
                        state_nxt = ST_WAIT_DONE;
                        n_nxt     = n + 2'd1;
                    end
                end
                ST_RUN, ST_FAULT: begin
                end
                default: state_nxt = ST_ASSERT;
            endcase
        end

        if (state_nxt != state) cnt_nxt = 24'd0;
        if (state_nxt == ST_ASSERT) n_nxt = 2'd0;

        // stages 0..n are out of reset while waiting on / spacing stage n
        unique case (state_nxt)
            ST_WAIT_DONE, ST_GAP: rst_nxt = 3'b110 << n_nxt;
            ST_RUN:               rst_nxt = 3'b000;
            default:              rst_nxt = 3'b111;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= ST_ASSERT;
            cnt               <= 24'd0;
            n                 <= 2'd0;
            bus.rst_stage     <= 3'b111;
            bus.seq_ready     <= 1'b0;
            bus.fault         <= 1'b0;
            bus.fault_stage   <= 2'd0;
            bus.lock_loss_cnt <= 8'd0;
        end else begin
            state             <= state_nxt;
            cnt               <= cnt_nxt;
            n                 <= n_nxt;
            bus.rst_stage     <= rst_nxt;
            bus.seq_ready     <= (state_nxt == ST_RUN);
            bus.fault         <= (state_nxt == ST_FAULT);
            bus.fault_stage   <= fstage_nxt;
            bus.lock_loss_cnt <= llc_nxt;
        end
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench for reset_sequencer against an edge-time schedule model.
// The model predicts, per sequence, the edge at which each stage is released.
module tb_reset_sequencer;
    localparam int HOLD = 4;
    localparam int GAP  = 3;
    localparam int TO   = 10;
    localparam int BIG  = 1 << 30;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_checks = 0;
    int   n_fail   = 0;

    // schedule: f[i] = edge where rst_stage[i] falls, run_e/fault_e edges
    int f[3];
    int d[3];
    int run_e;
    int fault_e;
    int fault_n;
    int exp_llc;

    logic [4:0] got;

    reset_sequencer_if bus();

    reset_sequencer #(
        .HOLD_CYCLES (HOLD),
        .STAGE_GAP   (GAP),
        .DONE_TIMEOUT(TO)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    assign got = {bus.rst_stage, bus.seq_ready, bus.fault};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (cyc > 60000) begin
            $display("FAIL watchdog: cycle %0d exceeds budget", cyc);
            $fatal(1, "watchdog");
        end
    end

    // a = edge after which the sequencer sits in ASSERT with count 0
    function automatic void plan(int a, int x0, int x1, int x2);
        int e;
        int nx;
        d[0] = x0; d[1] = x1; d[2] = x2;
        f[0] = a + ((HOLD < 2) ? 2 : HOLD) + 1;
        f[1] = BIG; f[2] = BIG;
        run_e = BIG; fault_e = BIG; fault_n = 0;
        for (int i = 0; i < 3; i++) begin
            if (f[i] != BIG && fault_e == BIG) begin
                if (d[i] >= TO) begin
                    fault_e = f[i] + TO;
                    fault_n = i;
                end else begin
                    e = f[i] + d[i] + 1;
                    if (i == 2) run_e = e;
                    else begin
                        nx = i + 1;
                        f[nx] = e + GAP;
                    end
                end
            end
        end
    endfunction

    function automatic logic [4:0] exp_out(int k);
        logic [4:0] e;
        for (int i = 0; i < 3; i++)
            e[i + 2] = (k < f[i]) || (k >= fault_e);
        e[1] = (k >= run_e);
        e[0] = (k >= fault_e);
        return e;
    endfunction

    function automatic int rd(int hi);
        return int'($urandom_range(0, hi));
    endfunction

    // advance one edge; stage_done is noise until that stage's turn
    task automatic tick();
        @(posedge clk);
        #1;
        bus.soft_reset_req = 1'b0;
        for (int i = 0; i < 3; i++)
            bus.stage_done[i] = (cyc < f[i]) ? 1'($urandom_range(0, 1))
                                             : (cyc >= f[i] + d[i]);
    endtask

    task automatic do_reset(input int m, output int a);
        reset = 1'b1;
        repeat (m) tick();
        a = cyc;
        reset = 1'b0;
        exp_llc = 0;
    endtask

    task automatic test_reset();
        plan(BIG, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.locked = 1'($urandom_range(0, 1));
            bus.soft_reset_req = 1'($urandom_range(0, 1));
            n_checks++;
            if ({got, bus.fault_stage, bus.lock_loss_cnt} !== 15'b11100_00_00000000) begin
                n_fail++;
                $display("FAIL reset_vals cyc=%0d got=%b/%0d/%0d exp=11100/0/0",
                         cyc, got, bus.fault_stage, bus.lock_loss_cnt);
            end
        end
    endtask

    task automatic test_nominal();
        int a;
        bus.locked = 1'b1;
        do_reset(2, a);
        plan(a, 2, 2, 2);
        while (cyc < run_e + 3) begin
            tick();
            n_checks++;
            if (got !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL nominal cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
            end
        end
        n_checks++;
        if (bus.lock_loss_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL nominal_llc got=%0d exp=0", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_random_seq();
        int a;
        int s;
        int end_k;
        for (int it = 0; it < 6; it++) begin
            bus.locked = 1'b1;
            do_reset(1 + rd(2), a);
            plan(a, rd(12), rd(12), rd(12));
            end_k = ((run_e < fault_e) ? run_e : fault_e) + 2;
            while (cyc < end_k) begin
                tick();
                n_checks++;
                if (got !== exp_out(cyc)) begin
                    n_fail++;
                    $display("FAIL rand_seq cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
                end
            end
            if (fault_e != BIG) begin
                n_checks++;
                if (bus.fault_stage !== 2'(fault_n)) begin
                    n_fail++;
                    $display("FAIL rand_fstage got=%0d exp=%0d", bus.fault_stage, fault_n);
                end
            end
            s = cyc + 2 + rd(3);
            end_k = BIG;
            while (cyc < end_k) begin
                tick();
                n_checks++;
                if (got !== exp_out(cyc)) begin
                    n_fail++;
                    $display("FAIL rand_soft cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
                end
                if (cyc == s - 1) begin
                    bus.soft_reset_req = 1'b1;
                    plan(s, rd(9), rd(9), rd(9));
                    end_k = run_e + 2;
                end
            end
        end
    endtask

    task automatic test_timeout();
        int a;
        int l;
        int s;
        int end_k;
        bus.locked = 1'b1;
        do_reset(1, a);
        plan(a, 2, 20, 2);
        while (cyc < fault_e + 2) begin
            tick();
            n_checks++;
            if (got !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL timeout cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
            end
        end
        n_checks++;
        if (bus.fault_stage !== 2'd1) begin
            n_fail++;
            $display("FAIL timeout_fstage got=%0d exp=1", bus.fault_stage);
        end
        l = cyc + 1;
        s = cyc + 8;
        end_k = BIG;
        while (cyc < end_k) begin
            tick();
            n_checks++;
            if (got !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL fault_exit cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
            end
            if (cyc == l) bus.locked = 1'b0;
            if (cyc == l + 1) bus.locked = 1'b1;
            if (cyc == s - 1) begin
                n_checks++;
                if (bus.lock_loss_cnt !== 8'(exp_llc)) begin
                    n_fail++;
                    $display("FAIL fault_llc got=%0d exp=%0d", bus.lock_loss_cnt, exp_llc);
                end
                bus.soft_reset_req = 1'b1;
                plan(s, 2, 2, 2);
                end_k = run_e + 2;
            end
        end
    endtask

    task automatic test_lock_loss();
        int a;
        int l;
        int end_k;
        bus.locked = 1'b1;
        do_reset(1, a);
        plan(a, rd(9), rd(9), rd(9));
        for (int it = 0; it < 4; it++) begin
            l = ((f[0] - 2 > cyc + 1) ? f[0] - 2 : cyc + 1) + rd(20);
            end_k = BIG;
            while (cyc < end_k) begin
                tick();
                n_checks++;
                if (got !== exp_out(cyc)) begin
                    n_fail++;
                    $display("FAIL lock_loss cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
                end
                if (cyc == l) bus.locked = 1'b0;
                if (cyc == l + 1) bus.locked = 1'b1;
                if (cyc == l + 2) begin
                    plan(l + 3, rd(9), rd(9), rd(9));
                    exp_llc++;
                    end_k = run_e + 2;
                end
                if (cyc == l + 3) begin
                    n_checks++;
                    if (bus.lock_loss_cnt !== 8'(exp_llc)) begin
                        n_fail++;
                        $display("FAIL lock_llc got=%0d exp=%0d", bus.lock_loss_cnt, exp_llc);
                    end
                end
            end
        end
    endtask

    task automatic test_simultaneous();
        int a;
        int l;
        int sa;
        int end_k;
        bus.locked = 1'b1;
        do_reset(1, a);
        plan(a, 1, 1, 1);
        while (cyc < run_e + 2) tick();
        l = cyc + 1;
        sa = -1;
        end_k = BIG;
        while (cyc < end_k) begin
            tick();
            n_checks++;
            if (got !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL simul cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
            end
            if (cyc == l) bus.locked = 1'b0;
            if (cyc == l + 1) bus.locked = 1'b1;
            if (cyc == l + 2) begin
                bus.soft_reset_req = 1'b1;
                plan(l + 3, 1, 1, 1);
                exp_llc++;
                sa = l + 3 + rd(HOLD - 1);
                end_k = run_e + 2;
            end
            if (cyc == sa) bus.soft_reset_req = 1'b1;
        end
        n_checks++;
        if (bus.lock_loss_cnt !== 8'd1) begin
            n_fail++;
            $display("FAIL simul_llc got=%0d exp=1", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_saturation();
        int a;
        int l;
        bus.locked = 1'b1;
        do_reset(1, a);
        plan(a, 50, 50, 50);
        for (int e = 0; e < 260; e++) begin
            while (cyc < f[0] - 2) tick();
            l = cyc;
            bus.locked = 1'b0;
            tick();
            bus.locked = 1'b1;
            tick();
            plan(l + 3, 50, 50, 50);
            if (exp_llc < 255) exp_llc++;
            tick();
            n_checks++;
            if (bus.lock_loss_cnt !== 8'(exp_llc) || bus.rst_stage !== 3'b111) begin
                n_fail++;
                $display("FAIL sat_llc ev=%0d got=%0d/%b exp=%0d/111",
                         e, bus.lock_loss_cnt, bus.rst_stage, exp_llc);
            end
        end
        n_checks++;
        if (bus.lock_loss_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final got=%0d exp=255", bus.lock_loss_cnt);
        end
    endtask

    task automatic test_reset_mid_gap();
        int a;
        int l;
        int r;
        int end_k;
        bus.locked = 1'b1;
        do_reset(1, a);
        plan(a, 2, 2, 2);
        l = f[0] - 2;
        r = -10;
        end_k = BIG;
        while (cyc < end_k) begin
            tick();
            n_checks++;
            if (got !== exp_out(cyc)) begin
                n_fail++;
                $display("FAIL mid_gap cyc=%0d got=%b exp=%b", cyc, got, exp_out(cyc));
            end
            if (cyc == l) bus.locked = 1'b0;
            if (cyc == l + 1) bus.locked = 1'b1;
            if (cyc == l + 2) begin
                plan(l + 3, 2, 2, 2);
                exp_llc++;
                r = f[1] - GAP + 1 + rd(GAP - 1);
            end
            if (cyc == r - 1) begin
                reset = 1'b1;
                plan(BIG, 0, 0, 0);
            end
            if (cyc == r) begin
                n_checks++;
                if (bus.lock_loss_cnt !== 8'd0 || bus.fault_stage !== 2'd0) begin
                    n_fail++;
                    $display("FAIL mid_gap_rst got=%0d/%0d exp=0/0",
                             bus.lock_loss_cnt, bus.fault_stage);
                end
            end
            if (cyc == r + 1) begin
                reset = 1'b0;
                exp_llc = 0;
                plan(r + 1, 2, 2, 2);
                end_k = run_e + 2;
            end
        end
    endtask

    initial begin
        bus.locked = 1'b0;
        bus.soft_reset_req = 1'b0;
        bus.stage_done = 3'b000;
        f = '{BIG, BIG, BIG};
        d = '{0, 0, 0};
        run_e = BIG;
        fault_e = BIG;
        fault_n = 0;
        exp_llc = 0;
        test_reset();
        test_nominal();
        test_random_seq();
        test_timeout();
        test_lock_loss();
        test_simultaneous();
        test_saturation();
        test_reset_mid_gap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
